// File: rtl/mux_n_1_stream_rr_if.sv
// Stream bundle between N producers, the N:1 mux and a single consumer.
// The mux sits on the slave side; the producers and the consumer together form the master side.
interface mux_n_1_stream_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_n_1_stream_rr.sv
// N-channel valid/ready stream mux with a 1-deep registered output.
// The grant comes either from an external select or from a round-robin pointer.
module mux_n_1_stream_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  mux_n_1_stream_rr_if.slave bus
);

  logic [WIDTH-1:0] chan_data [N];
  logic             load;
  logic             grant_valid;
  logic [SW-1:0]    grant_idx;
  int               rr_idx;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SW-1:0]    out_sel_reg;
  logic [SW-1:0]    rr_ptr_reg;

  assign load = !out_valid_reg || bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi]    = bus.in_data[gi*WIDTH +: WIDTH];
      assign bus.in_ready[gi] = !rst && load && grant_valid && (grant_idx == SW'(gi));
    end
  endgenerate

  // Matching sel against each legal index keeps out-of-range selects from ever granting.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SW'(i);
        end
      end
    end else begin
      // Scan farthest-first so the closest requester after rr_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        rr_idx = int'(rr_ptr_reg) + k;
        if (rr_idx >= N) rr_idx = rr_idx - N;
        if (bus.in_valid[rr_idx[SW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx[SW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[grant_idx];
        out_sel_reg   <= grant_idx;
        if (mode) begin
          rr_ptr_reg <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_n_1_stream_rr.sv
// Directed bench for the N:1 round-robin stream mux: linear steps with hand-computed
// expectations, plus a transfer scoreboard and a one-hot check on in_ready.
module tb_mux_n_1_stream_rr;
  localparam int N = 4;
  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [1:0] sel;

  int compared = 0;
  int mismatched = 0;

  mux_n_1_stream_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

  mux_n_1_stream_rr #(.N(N), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, bus.out_valid, v);
    chk({tag, ".data"}, bus.out_data, d);
    chk({tag, ".sel"}, bus.out_sel, s);
    $display("step %s: out_valid=%0d out_data=%0h out_sel=%0d", tag, bus.out_valid, bus.out_data, bus.out_sel);
  endtask

  // in_ready must never have more than one bit set
  always @(negedge clk) begin
    chk("onehot0", {31'd0, $onehot0(bus.in_ready)}, 32'd1);
  end

  // Scoreboard: every observed transfer must appear at the output one cycle later.
  initial begin
    logic       hit;
    logic [1:0] ch;
    logic [3:0] dat;
    forever begin
      @(negedge clk);
      hit = 1'b0;
      ch  = '0;
      dat = '0;
      for (int i = 0; i < N; i++) begin
        if (bus.in_valid[i] === 1'b1 && bus.in_ready[i] === 1'b1) begin
          hit = 1'b1;
          ch  = 2'(i);
          dat = bus.in_data[i*WIDTH +: WIDTH];
        end
      end
      @(posedge clk);
      #1;
      if (hit) begin
        chk("sb.valid", bus.out_valid, 1'b1);
        chk("sb.sel", bus.out_sel, ch);
        chk("sb.data", bus.out_data, dat);
      end
    end
  end

  initial begin
    rst = 1'b1;
    mode = 1'b1;
    sel = 2'd0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);

    // 1: reset held two cycles with every channel requesting
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("t1.in_ready", bus.in_ready, 4'b0000);
      chk_out("t1", 1'b0, 4'h0, 2'd0);
    end

    // 2: fixed select of channel 2
    rst = 1'b0;
    mode = 1'b0;
    sel = 2'd2;
    bus.in_valid = 4'b0100;
    set_data(4'h0, 4'h0, 4'hA, 4'h0);
    #1;
    chk("t2.in_ready", bus.in_ready, 4'b0100);
    tick;
    chk_out("t2", 1'b1, 4'hA, 2'd2);

    // 3: round robin over four busy channels at full throughput
    mode = 1'b1;
    bus.in_valid = 4'b1111;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    #1;
    chk("t3.in_ready", bus.in_ready, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk_out("t3", 1'b1, 4'(c % 4 + 1), 2'(c % 4));
    end

    // 4: backpressure while holding data 5
    mode = 1'b0;
    sel = 2'd1;
    bus.in_valid = 4'b0010;
    set_data(4'h0, 4'h5, 4'h0, 4'h0);
    tick;
    chk_out("t4.load", 1'b1, 4'h5, 2'd1);
    bus.out_ready = 1'b0;
    sel = 2'd2;
    bus.in_valid = 4'b0100;
    set_data(4'h0, 4'h5, 4'h6, 4'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4.stall_ready", bus.in_ready, 4'b0000);
      tick;
      chk_out("t4.stall", 1'b1, 4'h5, 2'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4.release_ready", bus.in_ready, 4'b0100);
    tick;
    chk_out("t4.release", 1'b1, 4'h6, 2'd2);

    // 5: rr_ptr is 1; grant ch2 moves it to 3, then ch1 wins by wrapping
    mode = 1'b1;
    bus.in_valid = 4'b0100;
    tick;
    chk_out("t5.ch2", 1'b1, 4'h6, 2'd2);
    bus.in_valid = 4'b0010;
    set_data(4'h0, 4'h7, 4'h0, 4'h0);
    #1;
    chk("t5.wrap_ready", bus.in_ready, 4'b0010);
    tick;
    chk_out("t5.wrap", 1'b1, 4'h7, 2'd1);
    bus.in_valid = 4'b0000;
    #1;
    chk("t5.idle_ready", bus.in_ready, 4'b0000);
    tick;
    chk_out("t5.drop", 1'b0, 4'h7, 2'd1);
    // mode-0 transfer leaves rr_ptr at 2
    mode = 1'b0;
    sel = 2'd3;
    bus.in_valid = 4'b1000;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    tick;
    chk_out("t5.fixed3", 1'b1, 4'h4, 2'd3);

    // 6: reset mid-stream with a held word and rr_ptr=2
    mode = 1'b1;
    bus.in_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("t6.rst_ready", bus.in_ready, 4'b0000);
    tick;
    chk_out("t6.rst", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;
    #1;
    chk("t6.cold_ready", bus.in_ready, 4'b0001);
    tick;
    chk_out("t6.cold0", 1'b1, 4'h1, 2'd0);
    tick;
    chk_out("t6.cold1", 1'b1, 4'h2, 2'd1);

    bus.in_valid = 4'b0000;
    tick;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
